// File: rtl/cache_pkg.sv
// Shared constants and types for the cache miss controller: block geometry,
// fill state encoding and fill-target select.
package cache_pkg;

    localparam int OFFSET_W        = 4;
    localparam int WORDS_PER_BLOCK = 8;
    localparam int CNT_W           = 4;

    typedef enum logic {
        FILL_IDLE   = 1'b0,
        FILL_ACTIVE = 1'b1
    } fill_state_t;

    typedef enum logic {
        TGT_D = 1'b0,
        TGT_I = 1'b1
    } target_t;

endpackage

// File: rtl/cache_miss_controller_if.sv
// Miss request, memory read port and cache fill strobes between the miss
// controller (master) and the caches/memory around it (slave).
interface cache_miss_controller_if #(
    parameter int AWIDTH = 16
);

    logic              d_cache_miss_detected;
    logic [AWIDTH-1:0] d_cache_miss_address;
    logic              i_cache_miss_detected;
    logic [AWIDTH-1:0] i_cache_miss_address;
    logic              memory_data_valid;

    logic [AWIDTH-1:0] memory_address;
    logic              memory_enable;
    logic              fill_busy;
    logic [AWIDTH-1:0] fill_address;
    logic              d_cache_fsm_data_wen;
    logic              i_cache_fsm_data_wen;
    logic              d_cache_fsm_tag_wen;
    logic              i_cache_fsm_tag_wen;

    modport master (
        input  d_cache_miss_detected,
        input  d_cache_miss_address,
        input  i_cache_miss_detected,
        input  i_cache_miss_address,
        input  memory_data_valid,
        output memory_address,
        output memory_enable,
        output fill_busy,
        output fill_address,
        output d_cache_fsm_data_wen,
        output i_cache_fsm_data_wen,
        output d_cache_fsm_tag_wen,
        output i_cache_fsm_tag_wen
    );

    modport slave (
        output d_cache_miss_detected,
        output d_cache_miss_address,
        output i_cache_miss_detected,
        output i_cache_miss_address,
        output memory_data_valid,
        input  memory_address,
        input  memory_enable,
        input  fill_busy,
        input  fill_address,
        input  d_cache_fsm_data_wen,
        input  i_cache_fsm_data_wen,
        input  d_cache_fsm_tag_wen,
        input  i_cache_fsm_tag_wen
    );

endinterface

// File: rtl/cache_miss_controller_word_counter.sv
// Small enabled up-counter with synchronous clear; used to index the words
// of a block on both the issue and the receive side of a fill.
module word_counter
    import cache_pkg::*;
#(
    parameter int WIDTH = CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/cache_miss_controller.sv
// Shared I/D-cache miss handler: arbitrates misses (D first), streams one block
// from the pipelined memory, strobes per-word data writes, then the tag write.
module cache_miss_controller #(
    parameter int AWIDTH          = 16,
    parameter int DWIDTH          = 16,
    parameter int WORDS_PER_BLOCK = cache_pkg::WORDS_PER_BLOCK
) (
    input  logic                    clk,
    input  logic                    rst,
    cache_miss_controller_if.master bus
);

    import cache_pkg::*;

    localparam int              WORD_BYTES  = DWIDTH / 8;
    localparam logic [CNT_W-1:0] BLOCK_WORDS = CNT_W'(WORDS_PER_BLOCK);
    localparam logic [CNT_W-1:0] LAST_WORD   = CNT_W'(WORDS_PER_BLOCK - 1);

    fill_state_t       state;
    fill_state_t       state_next;
    target_t           target;
    target_t           target_next;
    logic [AWIDTH-1:0] base;
    logic [AWIDTH-1:0] base_next;

    logic [CNT_W-1:0]  ic;
    logic [CNT_W-1:0]  rc;
    logic              issue_step;
    logic              recv_step;
    logic              counters_clear;

    logic [AWIDTH-1:0] issue_offset;
    logic [AWIDTH-1:0] recv_offset;
    logic [AWIDTH-1:0] d_block_base;
    logic [AWIDTH-1:0] i_block_base;

    logic              mem_en;
    logic [AWIDTH-1:0] mem_addr;
    logic [AWIDTH-1:0] fill_addr;
    logic              word_wen;
    logic              last_word;

    logic              unused_offset_bits;

    // The byte offset inside a block never exceeds 14, so adding it to the
    // block-aligned base cannot carry into the tag/index bits.
    assign issue_offset = AWIDTH'(ic) * AWIDTH'(WORD_BYTES);
    assign recv_offset  = AWIDTH'(rc) * AWIDTH'(WORD_BYTES);

    assign d_block_base = {bus.d_cache_miss_address[AWIDTH-1:OFFSET_W], OFFSET_W'(0)};
    assign i_block_base = {bus.i_cache_miss_address[AWIDTH-1:OFFSET_W], OFFSET_W'(0)};
    assign unused_offset_bits = ^{bus.d_cache_miss_address[OFFSET_W-1:0],
                                  bus.i_cache_miss_address[OFFSET_W-1:0]};

    word_counter #(
        .WIDTH (CNT_W)
    ) u_issue_counter (
        .clk    (clk),
        .rst    (rst),
        .clear  (counters_clear),
        .enable (issue_step),
        .count  (ic)
    );

    word_counter #(
        .WIDTH (CNT_W)
    ) u_recv_counter (
        .clk    (clk),
        .rst    (rst),
        .clear  (counters_clear),
        .enable (recv_step),
        .count  (rc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= FILL_IDLE;
            target <= TGT_D;
            base   <= '0;
        end else begin
            state  <= state_next;
            target <= target_next;
            base   <= base_next;
        end
    end

    // Issue and receive sides run independently inside FILL_ACTIVE; only the
    // arrival of the last word decides when the fill retires.
    always_comb begin
        state_next     = state;
        target_next    = target;
        base_next      = base;
        issue_step     = 1'b0;
        recv_step      = 1'b0;
        counters_clear = 1'b0;
        mem_en         = 1'b0;
        mem_addr       = '0;
        fill_addr      = '0;
        word_wen       = 1'b0;
        last_word      = 1'b0;

        case (state)
            FILL_IDLE: begin
                counters_clear = 1'b1;
                if (bus.d_cache_miss_detected) begin
                    state_next  = FILL_ACTIVE;
                    target_next = TGT_D;
                    base_next   = d_block_base;
                end else if (bus.i_cache_miss_detected) begin
                    state_next  = FILL_ACTIVE;
                    target_next = TGT_I;
                    base_next   = i_block_base;
                end
            end

            FILL_ACTIVE: begin
                if (ic < BLOCK_WORDS) begin
                    mem_en     = 1'b1;
                    mem_addr   = base + issue_offset;
                    issue_step = 1'b1;
                end
                if (bus.memory_data_valid) begin
                    word_wen  = 1'b1;
                    fill_addr = base + recv_offset;
                    recv_step = 1'b1;
                    if (rc == LAST_WORD) begin
                        last_word  = 1'b1;
                        state_next = FILL_IDLE;
                    end
                end
            end

            default: begin
                state_next = FILL_IDLE;
            end
        endcase
    end

    assign bus.memory_enable  = mem_en;
    assign bus.memory_address = mem_addr;
    assign bus.fill_busy      = (state == FILL_ACTIVE);
    assign bus.fill_address   = fill_addr;

    assign bus.d_cache_fsm_data_wen = word_wen  && (target == TGT_D);
    assign bus.i_cache_fsm_data_wen = word_wen  && (target == TGT_I);
    assign bus.d_cache_fsm_tag_wen  = last_word && (target == TGT_D);
    assign bus.i_cache_fsm_tag_wen  = last_word && (target == TGT_I);

    // Structural invariants of the fill strobes.
    a_one_target : assert property (@(posedge clk) disable iff (rst)
        !(bus.d_cache_fsm_data_wen && bus.i_cache_fsm_data_wen));
    a_tag_with_data : assert property (@(posedge clk) disable iff (rst)
        (bus.d_cache_fsm_tag_wen || bus.i_cache_fsm_tag_wen) |-> word_wen);

endmodule

// File: tb/tb_cache_miss_controller.sv
// Self-checking bench for cache_miss_controller: a 4-cycle memory model, a
// timeline reference model of the fill, directed vectors and random traffic.
module tb_cache_miss_controller;

    typedef struct {
        logic        dm;
        logic [15:0] da;
        logic        en;
        logic [15:0] maddr;
        logic        busy;
        logic [15:0] faddr;
        logic [3:0]  strobes;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    cache_miss_controller_if #(.AWIDTH(16)) bus ();

    cache_miss_controller #(
        .AWIDTH          (16),
        .DWIDTH          (16),
        .WORDS_PER_BLOCK (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    // memory4c stand-in: read data returns four cycles after the request
    logic [3:0] pipe = 4'b0;

    // reference model: a fill is a 12-cycle timeline after the accept cycle
    bit          m_busy = 1'b0;
    bit          m_tgt  = 1'b0;
    logic [15:0] m_base = 16'h0;
    int          m_k    = 0;
    bit          exp_dtag_now;
    bit          exp_itag_now;

    int d_tag_cycle = -1;
    int i_tag_cycle = -1;

    vec_t vecs[14];

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic applyStimulus(input bit r, input bit dm, input logic [15:0] da,
                                 input bit im, input logic [15:0] ia, input bit stray,
                                 input bit chk);
        bit          exp_en;
        bit          exp_word;
        logic [15:0] exp_maddr;
        logic [15:0] exp_faddr;
        logic [3:0]  exp_strobes;
        logic [3:0]  act_strobes;

        @(negedge clk);
        rst                       = r;
        bus.d_cache_miss_detected = dm;
        bus.d_cache_miss_address  = da;
        bus.i_cache_miss_detected = im;
        bus.i_cache_miss_address  = ia;
        bus.memory_data_valid     = pipe[3] | stray;
        #1;

        exp_en      = m_busy && (m_k <= 8);
        exp_maddr   = exp_en ? m_base + 16'(2 * (m_k - 1)) : 16'h0;
        exp_word    = m_busy && (m_k >= 5) && (m_k <= 12);
        exp_faddr   = exp_word ? m_base + 16'(2 * (m_k - 5)) : 16'h0;
        exp_dtag_now = exp_word && !m_tgt && (m_k == 12);
        exp_itag_now = exp_word &&  m_tgt && (m_k == 12);
        exp_strobes = {exp_word && !m_tgt, exp_dtag_now, exp_word && m_tgt, exp_itag_now};
        act_strobes = {bus.d_cache_fsm_data_wen, bus.d_cache_fsm_tag_wen,
                       bus.i_cache_fsm_data_wen, bus.i_cache_fsm_tag_wen};

        if (chk) begin
            checkOutput("fill_busy",      16'(bus.fill_busy),     16'(m_busy));
            checkOutput("memory_enable",  16'(bus.memory_enable), 16'(exp_en));
            checkOutput("memory_address", bus.memory_address,     exp_maddr);
            checkOutput("fill_address",   bus.fill_address,       exp_faddr);
            checkOutput("strobes",        16'(act_strobes),       16'(exp_strobes));
        end

        if (bus.d_cache_fsm_tag_wen === 1'b1) d_tag_cycle = cyc;
        if (bus.i_cache_fsm_tag_wen === 1'b1) i_tag_cycle = cyc;

        if (r) begin
            m_busy = 1'b0;
        end else if (m_busy) begin
            if (m_k == 12) m_busy = 1'b0;
            else           m_k++;
        end else if (dm) begin
            m_busy = 1'b1; m_tgt = 1'b0; m_base = da & 16'hFFF0; m_k = 1;
        end else if (im) begin
            m_busy = 1'b1; m_tgt = 1'b1; m_base = ia & 16'hFFF0; m_k = 1;
        end

        pipe = r ? 4'b0 : {pipe[2:0], bus.memory_enable};
        cyc++;
    endtask

    task automatic runIdle(input int n);
        for (int j = 0; j < n; j++) applyStimulus(0, 0, 16'h0, 0, 16'h0, 0, 1);
    endtask

    initial begin
        int          t0;
        bit          dp;
        bit          ip;
        logic [15:0] da;
        logic [15:0] ia;
        bit          stray;
        bit          r;

        rst = 1'b1;
        bus.d_cache_miss_detected = 1'b0;
        bus.d_cache_miss_address  = 16'h0;
        bus.i_cache_miss_detected = 1'b0;
        bus.i_cache_miss_address  = 16'h0;
        bus.memory_data_valid     = 1'b0;

        // D miss at 0x1236 seen at row 0; miss clears once the tag write retires
        for (int k = 0; k < 14; k++) begin
            vecs[k].dm      = (k < 13);
            vecs[k].da      = 16'h1236;
            vecs[k].en      = (k >= 1 && k <= 8);
            vecs[k].maddr   = vecs[k].en ? 16'h1230 + 16'(2 * (k - 1)) : 16'h0;
            vecs[k].busy    = (k >= 1 && k <= 12);
            vecs[k].faddr   = (k >= 5 && k <= 12) ? 16'h1230 + 16'(2 * (k - 5)) : 16'h0;
            vecs[k].strobes = {(k >= 5 && k <= 12), (k == 12), 1'b0, 1'b0};
        end

        applyStimulus(1, 0, 16'h0, 0, 16'h0, 0, 0);
        applyStimulus(1, 0, 16'h0, 0, 16'h0, 0, 0);
        runIdle(2);

        $display("[TB] D miss vector table");
        for (int k = 0; k < 14; k++) begin
            applyStimulus(0, vecs[k].dm, vecs[k].da, 0, 16'h0, 0, 1);
            checkOutput("tbl_enable",  16'(bus.memory_enable), 16'(vecs[k].en));
            checkOutput("tbl_maddr",   bus.memory_address,     vecs[k].maddr);
            checkOutput("tbl_busy",    16'(bus.fill_busy),     16'(vecs[k].busy));
            checkOutput("tbl_faddr",   bus.fill_address,       vecs[k].faddr);
            checkOutput("tbl_strobes", 16'({bus.d_cache_fsm_data_wen, bus.d_cache_fsm_tag_wen,
                                            bus.i_cache_fsm_data_wen, bus.i_cache_fsm_tag_wen}),
                        16'(vecs[k].strobes));
        end

        $display("[TB] I miss at 0x00FF");
        t0 = cyc;
        for (int k = 0; k < 14; k++) begin
            applyStimulus(0, 0, 16'h0, (k < 13), 16'h00FF, 0, 1);
            if (k == 8) checkOutput("i_last_issue", bus.memory_address, 16'h00FE);
        end
        checkOutput("i_tag_cycle", 16'(i_tag_cycle - t0), 16'd12);

        $display("[TB] simultaneous D 0x4000 and I 0x0010");
        t0 = cyc;
        for (int k = 0; k < 27; k++) begin
            applyStimulus(0, (k < 13), 16'h4000, (k < 26), 16'h0010, 0, 1);
            if (k == 14) checkOutput("i_first_issue", bus.memory_address, 16'h0010);
        end
        checkOutput("sim_d_tag_cycle", 16'(d_tag_cycle - t0), 16'd12);
        checkOutput("sim_i_tag_cycle", 16'(i_tag_cycle - t0), 16'd25);

        $display("[TB] stray memory_data_valid in IDLE");
        applyStimulus(0, 0, 16'h0, 0, 16'h0, 1, 1);
        checkOutput("stray_strobes", 16'({bus.d_cache_fsm_data_wen, bus.i_cache_fsm_data_wen,
                                          bus.d_cache_fsm_tag_wen, bus.i_cache_fsm_tag_wen}), 16'h0);
        applyStimulus(0, 0, 16'h0, 0, 16'h0, 1, 1);
        runIdle(1);
        checkOutput("stray_idle", 16'(bus.fill_busy), 16'h0);

        $display("[TB] D miss dropped at T+3");
        t0 = cyc;
        for (int k = 0; k < 14; k++) applyStimulus(0, (k < 3), 16'hABCD, 0, 16'h0, 0, 1);
        checkOutput("drop_d_tag_cycle", 16'(d_tag_cycle - t0), 16'd12);

        $display("[TB] reset mid-fill");
        i_tag_cycle = -1;
        for (int k = 0; k < 7; k++) applyStimulus(0, 0, 16'h0, 1, 16'h2220, 0, 1);
        applyStimulus(1, 0, 16'h0, 0, 16'h0, 0, 1);
        applyStimulus(1, 0, 16'h0, 0, 16'h0, 0, 1);
        runIdle(6);
        checkOutput("rst_no_tag", 16'(i_tag_cycle), 16'hFFFF);
        t0 = cyc;
        for (int k = 0; k < 14; k++) applyStimulus(0, (k < 13), 16'h8888, 0, 16'h0, 0, 1);
        checkOutput("rst_after_tag", 16'(d_tag_cycle - t0), 16'd12);

        $display("[TB] randomized traffic");
        dp = 0; ip = 0; da = 16'h0; ia = 16'h0;
        for (int n = 0; n < 800; n++) begin
            if (!dp && $urandom_range(0, 7) == 0) begin dp = 1; da = 16'($urandom); end
            if (!ip && $urandom_range(0, 7) == 0) begin ip = 1; ia = 16'($urandom); end
            if (m_busy && $urandom_range(0, 31) == 0) begin
                if (m_tgt) ip = 0;
                else       dp = 0;
            end
            stray = !m_busy && (pipe == 4'b0) && ($urandom_range(0, 5) == 0);
            r     = ($urandom_range(0, 149) == 0);
            applyStimulus(r, dp, da, ip, ia, stray, 1);
            if (exp_dtag_now) dp = 0;
            if (exp_itag_now) ip = 0;
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
